regfile_sequencer: RTL and testbench

Front-end controller for the single-port 32×64-bit register file (one access per cycle, read or write; read data registered and valid the cycle after the read is issued; x0 reads return 0). Accepts operand-fetch/write-back requests from up to NREQ requesters (core pipeline, debug port), arbitrates round-robin, and serialises each request into a fixed write-then-read-rs1-then-read-rs2 sequence on the register-file port. Returns both operands with a valid/ready handshake.

---
 rtl/regfile_sequencer_pkg.sv | 16 +
 rtl/regfile_sequencer_rr_arbiter.sv | 47 ++++
 rtl/regfile_sequencer.sv | 120 ++++++++++++
 tb/tb_regfile_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sequencer_pkg.sv
// Shared types and constants for the register-file front-end sequencer.
package regfile_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD1,
    RD2,
    CAP,
    RESP
  } seq_state_t;

  localparam int              REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/regfile_sequencer_rr_arbiter.sv
// Round-robin arbiter: the requester after the last granted one has highest priority.
module regfile_sequencer_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0] last;
  logic            found;

  // Reset to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= ID_W'(NREQ - 1);
    end else if (advance) begin
      last <= grant_id;
    end
  end

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Serialises arbitrated operand-fetch/write-back requests onto a single-port
// register file as write, read rs1, read rs2, and returns both operands.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*5-1:0]        req_rs1,
  input  logic [NREQ*5-1:0]        req_rs2,
  input  logic [NREQ*5-1:0]        req_rd,
  input  logic [NREQ-1:0]          req_wr_en,
  input  logic [NREQ*XLEN-1:0]     req_wr_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [XLEN-1:0]          resp_rs1_data,
  output logic [XLEN-1:0]          resp_rs2_data,
  output logic [4:0]               rf_reg_num,
  output logic                     rf_write,
  output logic [XLEN-1:0]          rf_data_in,
  input  logic [XLEN-1:0]          rf_data_out
);

  localparam int ID_W = $clog2(NREQ);

  seq_state_t state, state_next;

  logic [NREQ-1:0]      grant;
  logic [ID_W-1:0]      grant_id;
  logic                 handshake;
  logic [REG_IDX_W-1:0] rs1_q, rs2_q, rd_q;
  logic                 wr_en_q;
  logic [XLEN-1:0]      wr_data_q;

  regfile_sequencer_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid),
    .advance  (handshake),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign handshake = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    resp_valid = 1'b0;
    rf_write   = 1'b0;
    rf_reg_num = REG_ZERO;
    rf_data_in = '0;
    case (state)
      IDLE: if (handshake) state_next = WR;
      WR: begin
        // x0 is hardwired; never strobe a write to it.
        rf_write   = wr_en_q && (rd_q != REG_ZERO);
        rf_reg_num = rd_q;
        rf_data_in = wr_data_q;
        state_next = RD1;
      end
      RD1: begin
        rf_reg_num = rs1_q;
        state_next = RD2;
      end
      RD2: begin
        rf_reg_num = rs2_q;
        state_next = CAP;
      end
      CAP: begin
        rf_reg_num = rs2_q;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data arrives one cycle after the index is presented, hence capture on RD2/CAP exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_q         <= REG_ZERO;
      rs2_q         <= REG_ZERO;
      rd_q          <= REG_ZERO;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      resp_id       <= '0;
      resp_rs1_data <= '0;
      resp_rs2_data <= '0;
    end else begin
      if (handshake) begin
        rs1_q     <= req_rs1[grant_id*REG_IDX_W +: REG_IDX_W];
        rs2_q     <= req_rs2[grant_id*REG_IDX_W +: REG_IDX_W];
        rd_q      <= req_rd[grant_id*REG_IDX_W +: REG_IDX_W];
        wr_en_q   <= req_wr_en[grant_id];
        wr_data_q <= req_wr_data[grant_id*XLEN +: XLEN];
        resp_id   <= grant_id;
      end
      if (state == RD2) resp_rs1_data <= rf_data_out;
      if (state == CAP) resp_rs2_data <= rf_data_out;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer with a behavioural single-port register file.
module tb_regfile_sequencer;

  localparam int NREQ = 2;
  localparam int XLEN = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*5-1:0] req_rs1, req_rs2, req_rd;
  logic [NREQ-1:0]   req_wr_en;
  logic [NREQ*XLEN-1:0] req_wr_data;
  logic              resp_valid, resp_ready;
  logic [0:0]        resp_id;
  logic [XLEN-1:0]   resp_rs1_data, resp_rs2_data;
  logic [4:0]        rf_reg_num;
  logic              rf_write;
  logic [XLEN-1:0]   rf_data_in, rf_data_out;

  typedef struct {
    int          id;
    logic [63:0] d1;
    logic [63:0] d2;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_pulses = 0;
  logic prev_valid = 1'b0;
  logic [XLEN-1:0] rf_mem [32];

  regfile_sequencer #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_rd        (req_rd),
    .req_wr_en     (req_wr_en),
    .req_wr_data   (req_wr_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_rs1_data (resp_rs1_data),
    .resp_rs2_data (resp_rs2_data),
    .rf_reg_num    (rf_reg_num),
    .rf_write      (rf_write),
    .rf_data_in    (rf_data_in),
    .rf_data_out   (rf_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: not cleared by reset, registered read, x0 reads zero.
  always @(posedge clk) begin
    if (rf_write) rf_mem[rf_reg_num] <= rf_data_in;
    rf_data_out <= (rf_reg_num == 5'd0) ? '0 : rf_mem[rf_reg_num];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: latency on first valid cycle, data on each response handshake.
  always @(negedge clk) begin
    if (rf_write) begin
      wr_pulses++;
      checkOutput("rf_write_x0", {63'd0, rf_reg_num == 5'd0}, 64'd0);
    end
    if (resp_valid && !prev_valid) begin
      if (sb.size() == 0) checkOutput("unexpected_resp", 64'd1, 64'd0);
      else checkOutput("latency", 64'(cyc - sb[0].acc), 64'd4);
    end
    if (resp_valid && resp_ready && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("resp_id", {63'd0, resp_id}, 64'(e.id));
      checkOutput("resp_rs1", resp_rs1_data, e.d1);
      checkOutput("resp_rs2", resp_rs2_data, e.d2);
    end
    prev_valid = resp_valid;
  end

  task automatic setFields(input int r, input logic we, input logic [4:0] rd,
                           input logic [63:0] wd, input logic [4:0] a, input logic [4:0] b);
    req_wr_en[r]          = we;
    req_rd[r*5 +: 5]      = rd;
    req_wr_data[r*64 +: 64] = wd;
    req_rs1[r*5 +: 5]     = a;
    req_rs2[r*5 +: 5]     = b;
  endtask

  task automatic applyStimulus(input int r, input logic we, input logic [4:0] rd,
                               input logic [63:0] wd, input logic [4:0] a, input logic [4:0] b,
                               input logic [63:0] e1, input logic [63:0] e2, input bit push);
    bit   ok = 1'b0;
    exp_t e;
    setFields(r, we, rd, wd, a, b);
    req_valid[r] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("accept_timeout", 64'd0, 64'd1);
      req_valid[r] = 1'b0;
      return;
    end
    e.id = r; e.d1 = e1; e.d2 = e2; e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
  endtask

  task automatic waitDrain();
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          w0;
    int          grants[$];
    int          exp_order[4];
    exp_t        e;
    logic [NREQ-1:0] gv;

    exp_order = '{0, 1, 0, 1};
    reset       = 1'b1;
    req_valid   = 2'b11;
    req_rs1     = '0;
    req_rs2     = '0;
    req_rd      = '0;
    req_wr_en   = '0;
    req_wr_data = '0;
    resp_ready  = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", {62'd0, req_ready}, 64'd0);
    checkOutput("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    checkOutput("rst_rf_write", {63'd0, rf_write}, 64'd0);
    checkOutput("rst_rs1_data", resp_rs1_data, 64'd0);
    req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] single request with read-after-write");
    w0 = wr_pulses;
    applyStimulus(0, 1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd0, 64'hDEAD, 64'd0, 1'b1);
    waitDrain();
    checkOutput("wr_pulse_single", 64'(wr_pulses - w0), 64'd1);

    $display("[TB] write to x0 suppressed");
    w0 = wr_pulses;
    applyStimulus(0, 1'b1, 5'd0, 64'h1234, 5'd0, 5'd5, 64'd0, 64'hDEAD, 1'b1);
    waitDrain();
    checkOutput("wr_pulse_x0", 64'(wr_pulses - w0), 64'd0);

    $display("[TB] preload x3 and x7");
    applyStimulus(1, 1'b1, 5'd3, 64'h33, 5'd3, 5'd5, 64'h33, 64'hDEAD, 1'b1);
    waitDrain();
    applyStimulus(0, 1'b1, 5'd7, 64'h77, 5'd7, 5'd3, 64'h77, 64'h33, 1'b1);
    waitDrain();

    $display("[TB] read-only request");
    w0 = wr_pulses;
    applyStimulus(1, 1'b0, 5'd3, 64'hBAD, 5'd3, 5'd7, 64'h33, 64'h77, 1'b1);
    waitDrain();
    checkOutput("wr_pulse_rdonly", 64'(wr_pulses - w0), 64'd0);

    $display("[TB] both requesters continuously valid");
    setFields(0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd7);
    setFields(1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd3);
    req_valid = 2'b11;
    for (int k = 0; k < 100 && grants.size() < 4; k++) begin
      @(negedge clk);
      gv = req_valid & req_ready;
      if (gv != '0) begin
        e.id  = gv[1] ? 1 : 0;
        e.d1  = gv[1] ? 64'hDEAD : 64'h33;
        e.d2  = gv[1] ? 64'h33 : 64'h77;
        e.acc = cyc + 1;
        sb.push_back(e);
        grants.push_back(e.id);
        @(posedge clk);
      end
    end
    #1 req_valid = '0;
    checkOutput("grant_count", 64'(grants.size()), 64'd4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      checkOutput("grant_order", 64'(grants[k]), 64'(exp_order[k]));
    waitDrain();

    $display("[TB] response stall");
    resp_ready = 1'b0;
    applyStimulus(0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd7, 64'hDEAD, 64'h77, 1'b1);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 20 && !resp_valid; k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("stall_valid", {63'd0, resp_valid}, 64'd1);
      checkOutput("stall_rs1", resp_rs1_data, 64'hDEAD);
      checkOutput("stall_rs2", resp_rs2_data, 64'h77);
      checkOutput("stall_req_ready", {62'd0, req_ready}, 64'd0);
      checkOutput("stall_rf_write", {63'd0, rf_write}, 64'd0);
    end
    req_valid[1] = 1'b0;
    resp_ready   = 1'b1;
    waitDrain();

    $display("[TB] reset during RD1");
    applyStimulus(1, 1'b1, 5'd9, 64'h99, 5'd9, 5'd9, 64'd0, 64'd0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    req_valid[1] = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_state", 64'(dut.state), 64'd0);
    checkOutput("mid_rst_req_ready", {62'd0, req_ready}, 64'd0);
    checkOutput("mid_rst_rf_num", {59'd0, rf_reg_num}, 64'd0);
    checkOutput("mid_rst_rf_write", {63'd0, rf_write}, 64'd0);
    checkOutput("mid_rst_rf_data", rf_data_in, 64'd0);
    checkOutput("mid_rst_resp_id", {63'd0, resp_id}, 64'd0);
    checkOutput("mid_rst_rs1", resp_rs1_data, 64'd0);
    checkOutput("mid_rst_rs2", resp_rs2_data, 64'd0);
    checkOutput("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(1, 1'b0, 5'd0, 64'd0, 5'd9, 5'd0, 64'h99, 64'd0, 1'b1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
